// File: rtl/pwm_deadtime_if.sv
// Register port bundle for pwm_deadtime.
// This carries the same re/we/addr/wdata/be/rdata/error signals that a TL-UL
// register adapter provides.
// The master side drives the access; the slave side returns read data and error.
interface pwm_deadtime_if #(
  parameter int AW = 8,
  parameter int DW = 32
);
  logic            re;
  logic            we;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] be;
  logic [DW-1:0]   rdata;
  logic            error;

  modport master (output re, we, addr, wdata, be, input rdata, error);
  modport slave  (input re, we, addr, wdata, be, output rdata, error);
endinterface

// File: rtl/pwm_deadtime.sv
// Dead-time insertion stage placed after the PWM core.
// It turns the single-ended pwm_i into complementary hs_o/ls_o gate drives and
// holds both low for max(DT,1) cycles around every switch.
// Optional feature macro PWM_DT_FAULT_EN adds three things:
//   - the fault_i input,
//   - the FAULT state,
//   - a sticky STATUS[3] bit that is cleared by writing 1 to it.
//
// state    | meaning
// IDLE  0  | disabled, both outputs off
// LS_ON 1  | low side conducting
// DT_H  2  | dead time before high side turns on
// HS_ON 3  | high side conducting
// DT_L  4  | dead time before low side turns on
// FAULT 5  | latched fault, both off until STATUS[3] is cleared
module pwm_deadtime #(
  parameter int DT_W = 8,
  parameter int AW   = 8,
  parameter int DW   = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  pwm_deadtime_if.slave bus,
  input  logic         pwm_i,
`ifdef PWM_DT_FAULT_EN
  input  logic         fault_i,
`endif
  output logic         hs_o,
  output logic         ls_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LS_ON = 3'd1,
    S_DT_H  = 3'd2,
    S_HS_ON = 3'd3,
    S_DT_L  = 3'd4,
    S_FAULT = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [DT_W-1:0] cnt_q, cnt_d;
  logic [DT_W-1:0] dt_rise, dt_fall;
  logic [DT_W-1:0] bmask;
  logic            ctrl_en;
  logic            pwm_q;
  logic            fault_in, fault_flag, w1c_ok, status_wr_err;
  logic            sel_ctrl, sel_rise, sel_fall, sel_stat, hit, wr_ok;
  logic            unused_bits;

  // A programmed dead time of zero still gets one dead cycle.
  function automatic logic [DT_W-1:0] clamp1(input logic [DT_W-1:0] v);
    return (v == '0) ? DT_W'(1) : v;
  endfunction

  assign sel_ctrl = (bus.addr == AW'('h00));
  assign sel_rise = (bus.addr == AW'('h04));
  assign sel_fall = (bus.addr == AW'('h08));
  assign sel_stat = (bus.addr == AW'('h0C));
  assign hit      = sel_ctrl | sel_rise | sel_fall | sel_stat;

`ifdef PWM_DT_FAULT_EN
  assign fault_in      = fault_i;
  assign status_wr_err = 1'b0;
  // Clearing the fault is refused while the fault input is still asserted.
  assign w1c_ok = wr_ok & sel_stat & bus.be[0] & bus.wdata[3] & ~fault_i;

  // Sticky fault flag; a new fault wins over a simultaneous clear.
  always_ff @(posedge clk_i) begin
    if (rst_i)        fault_flag <= 1'b0;
    else if (fault_i) fault_flag <= 1'b1;
    else if (w1c_ok)  fault_flag <= 1'b0;
  end
`else
  assign fault_in      = 1'b0;
  assign fault_flag    = 1'b0;
  assign w1c_ok        = 1'b0;
  assign status_wr_err = 1'b1;
`endif

  assign bus.error = ((bus.re | bus.we) & ~hit) | (bus.we & sel_stat & status_wr_err);
  assign wr_ok     = bus.we & ~bus.error;
  assign unused_bits = ^{bus.wdata, bus.be};

  // Expand the byte enables into a bit mask over the dead-time field.
  always_comb begin
    bmask = '0;
    for (int i = 0; i < DT_W; i++) bmask[i] = bus.be[i/8];
  end

  // Combinational read mux; unused bits and unselected cycles read as zero.
  always_comb begin
    bus.rdata = '0;
    if (bus.re) begin
      if (sel_ctrl) bus.rdata[0] = ctrl_en;
      if (sel_rise) bus.rdata[DT_W-1:0] = dt_rise;
      if (sel_fall) bus.rdata[DT_W-1:0] = dt_fall;
      if (sel_stat) bus.rdata[3:0] = {fault_flag, state_q};
    end
  end

  // Configuration registers with per-byte write enables.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_en <= 1'b0;
      dt_rise <= '0;
      dt_fall <= '0;
    end else if (wr_ok) begin
      if (sel_ctrl && bus.be[0]) ctrl_en <= bus.wdata[0];
      if (sel_rise) dt_rise <= (dt_rise & ~bmask) | (bus.wdata[DT_W-1:0] & bmask);
      if (sel_fall) dt_fall <= (dt_fall & ~bmask) | (bus.wdata[DT_W-1:0] & bmask);
    end
  end

  // Next-state and dead-time counter logic; fault beats enable, enable beats pwm.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (fault_in) begin
      state_d = S_FAULT;
    end else if (state_q == S_FAULT) begin
      if (w1c_ok) state_d = S_IDLE;
    end else if (!ctrl_en) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pwm_q) begin
            state_d = S_DT_H;
            cnt_d   = clamp1(dt_rise);
          end else begin
            state_d = S_DT_L;
            cnt_d   = clamp1(dt_fall);
          end
        end
        S_LS_ON: if (pwm_q) begin
          state_d = S_DT_H;
          cnt_d   = clamp1(dt_rise);
        end
        S_HS_ON: if (!pwm_q) begin
          state_d = S_DT_L;
          cnt_d   = clamp1(dt_fall);
        end
        S_DT_H: begin
          if (!pwm_q)                 state_d = S_LS_ON;
          else if (cnt_q <= DT_W'(1)) state_d = S_HS_ON;
          else                        cnt_d   = cnt_q - DT_W'(1);
        end
        S_DT_L: begin
          if (pwm_q)                  state_d = S_HS_ON;
          else if (cnt_q <= DT_W'(1)) state_d = S_LS_ON;
          else                        cnt_d   = cnt_q - DT_W'(1);
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State, counter, input sync and output registers.
  // The gate outputs decode the next state so they switch on the same edge as the state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pwm_q   <= 1'b0;
      hs_o    <= 1'b0;
      ls_o    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pwm_q   <= pwm_i;
      hs_o    <= (state_d == S_HS_ON);
      ls_o    <= (state_d == S_LS_ON);
    end
  end

endmodule

// File: tb/tb_pwm_deadtime.sv
// Scoreboard bench for pwm_deadtime.
// The stimulus process queues the expected value for each future cycle.
// A negedge monitor pops and checks those entries, and it also checks
// hs_o/ls_o for overlap on every cycle.
module tb_pwm_deadtime;
  localparam int AW = 8;
  localparam int DW = 32;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic pwm_i = 1'b0;
`ifdef PWM_DT_FAULT_EN
  logic fault_i = 1'b0;
`endif
  logic hs_o, ls_o;

  pwm_deadtime_if #(.AW(AW), .DW(DW)) bus ();

  pwm_deadtime #(.DT_W(8), .AW(AW), .DW(DW)) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .bus    (bus),
    .pwm_i  (pwm_i),
`ifdef PWM_DT_FAULT_EN
    .fault_i(fault_i),
`endif
    .hs_o   (hs_o),
    .ls_o   (ls_o)
  );

  always #5 clk_i = ~clk_i;

  // sel: 0 hs_o, 1 ls_o, 2 rdata, 3 error
  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Monitor: overlap check every cycle, then every expectation due this cycle.
  always @(negedge clk_i) begin
    exp_t        e;
    logic [31:0] act;
    if (!rst_i) begin
      vectors++;
      if (hs_o && ls_o) begin
        miscompares++;
        $display("FAIL overlap: cycle %0d hs_o=1 ls_o=1, required never both high", cyc);
      end
    end
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      case (e.sel)
        0:       act = {31'b0, hs_o};
        1:       act = {31'b0, ls_o};
        2:       act = bus.rdata;
        default: act = {31'b0, bus.error};
      endcase
      vectors++;
      if (e.cyc != cyc || act !== e.val) begin
        miscompares++;
        $display("FAIL %s: cycle %0d (due %0d) got 0x%0h, required 0x%0h",
                 e.name, cyc, e.cyc, act, e.val);
      end
    end
  end

  task automatic expect_at(input int off, input int sel, input logic [31:0] v, input string n);
    exp_t e;
    e.cyc  = cyc + off;
    e.sel  = sel;
    e.val  = v;
    e.name = n;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be, input logic err);
    bus.we = 1'b1; bus.addr = a; bus.wdata = d; bus.be = be;
    expect_at(0, 3, {31'b0, err}, "wr_error");
    tick(1);
    bus.we = 1'b0; bus.be = 4'h0; bus.wdata = '0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] d, input logic err, input string n);
    bus.re = 1'b1; bus.addr = a;
    expect_at(0, 2, d, n);
    expect_at(0, 3, {31'b0, err}, {n, "_error"});
    tick(1);
    bus.re = 1'b0;
  endtask

  initial begin
    bus.re = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0; bus.be = '0;
    tick(3);
    rst_i = 1'b0;
    expect_at(0, 0, 0, "reset_hs");
    expect_at(0, 1, 0, "reset_ls");
    rd(8'h00, 0, 0, "reset_ctrl");
    rd(8'h04, 0, 0, "reset_dt_rise");
    rd(8'h08, 0, 0, "reset_dt_fall");
    rd(8'h0C, 0, 0, "reset_status");

    // Enable with pwm low: IDLE -> DT_L (2 cycles) -> LS_ON
    wr(8'h04, 32'd4, 4'hF, 0);
    wr(8'h08, 32'd2, 4'hF, 0);
    rd(8'h04, 32'd4, 0, "dt_rise_rb");
    rd(8'h08, 32'd2, 0, "dt_fall_rb");
    wr(8'h00, 32'd1, 4'h1, 0);
    tick(5);
    expect_at(0, 1, 1, "en_ls_on");
    expect_at(0, 0, 0, "en_hs_off");
    rd(8'h0C, 32'd1, 0, "status_ls_on");

    // pwm rises at t0: ls off at t0+2, hs on at t0+6 (DT_RISE=4)
    pwm_i = 1'b1;
    expect_at(1, 1, 1, "rise_ls_still_on");
    expect_at(2, 1, 0, "rise_ls_off");
    expect_at(5, 0, 0, "rise_hs_still_off");
    expect_at(6, 0, 1, "rise_hs_on");
    expect_at(6, 1, 0, "rise_ls_stays_off");
    tick(8);
    rd(8'h0C, 32'd3, 0, "status_hs_on");

    // DT_FALL=0 clamps to a single dead cycle
    wr(8'h08, 32'd0, 4'hF, 0);
    pwm_i = 1'b0;
    expect_at(1, 0, 1, "fall_hs_still_on");
    expect_at(2, 0, 0, "fall_hs_off");
    expect_at(2, 1, 0, "fall_dead_ls");
    expect_at(3, 1, 1, "fall_ls_on");
    tick(5);
    rd(8'h0C, 32'd1, 0, "status_back_ls");

    // 3-cycle pulse with DT_RISE=10 is swallowed
    wr(8'h04, 32'd10, 4'h1, 0);
    pwm_i = 1'b1;
    expect_at(2, 1, 0, "pulse_ls_off");
    expect_at(3, 0, 0, "pulse_hs_off_a");
    expect_at(4, 1, 0, "pulse_ls_dead");
    expect_at(5, 0, 0, "pulse_hs_off_b");
    expect_at(5, 1, 1, "pulse_ls_back");
    tick(3);
    pwm_i = 1'b0;
    tick(4);
    rd(8'h0C, 32'd1, 0, "status_swallowed");

    // Byte enables
    wr(8'h04, 32'h55, 4'h0, 0);
    rd(8'h04, 32'd10, 0, "be_none_dt_rise");
    wr(8'h04, 32'h7, 4'hE, 0);
    rd(8'h04, 32'd10, 0, "be_upper_dt_rise");
    wr(8'h00, 32'h0, 4'hE, 0);
    rd(8'h00, 32'd1, 0, "be_upper_ctrl");

    // Error decode
    rd(8'h10, 32'd0, 1, "unmapped_rd");
    wr(8'h10, 32'd0, 4'hF, 1);
`ifndef PWM_DT_FAULT_EN
    wr(8'h0C, 32'hF, 4'hF, 1);
`endif
    rd(8'h00, 32'd1, 0, "ctrl_after_errors");

    // Clearing EN while HS_ON drops outputs on the following edge
    pwm_i = 1'b1;
    tick(14);
    rd(8'h0C, 32'd3, 0, "status_hs_on_2");
    wr(8'h00, 32'd0, 4'h1, 0);
    expect_at(0, 0, 1, "dis_hs_before");
    expect_at(1, 0, 0, "dis_hs_off");
    expect_at(1, 1, 0, "dis_ls_off");
    tick(2);
    rd(8'h0C, 32'd0, 0, "status_idle");

`ifdef PWM_DT_FAULT_EN
    pwm_i = 1'b0;
    wr(8'h00, 32'd1, 4'h1, 0);
    tick(4);
    rd(8'h0C, 32'd1, 0, "flt_status_ls_on");
    fault_i = 1'b1;
    expect_at(1, 1, 0, "flt_ls_off");
    tick(1);
    fault_i = 1'b0;
    rd(8'h0C, 32'h0D, 0, "flt_status");
    fault_i = 1'b1;
    wr(8'h0C, 32'h8, 4'h1, 0);
    fault_i = 1'b0;
    rd(8'h0C, 32'h0D, 0, "flt_w1c_blocked");
    wr(8'h0C, 32'h8, 4'h1, 0);
    rd(8'h0C, 32'h0, 0, "flt_cleared");
    expect_at(2, 1, 1, "flt_recover_ls");
    tick(4);
`endif

    tick(3);
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, required finish within time limit");
    $fatal(1);
  end
endmodule
